// File: rtl/mem_port_arbiter_pkg.sv
// arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_e : FSM state encoding (ARB_IDLE, ARB_REQ, ARB_RESP)
//   OWN_IF/OWN_LS : owner encoding, also the value driven on sel
//   ARB_AW/ARB_DW : default address/data widths
package arb_pkg;

  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, load/store port, memory port
// and the shared datapath select of the memory port arbiter.
//   slave  : arbiter view (requests and memory responses in; grants,
//            responses, memory request and sel out)
//   master : environment view (fetch/LSU stages plus memory)
interface mem_port_arbiter_if
  import arb_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
);

  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;

  logic            ls_req;
  logic            ls_we;
  logic [AW-1:0]   ls_addr;
  logic [DW-1:0]   ls_wdata;
  logic [DW/8-1:0] ls_wstrb;
  logic            ls_gnt;
  logic            ls_rvalid;
  logic [DW-1:0]   ls_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  logic            sel;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output sel
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  sel
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick: combinational winner selection between fetch and load/store.
// Build option ARB_ROUND_ROBIN_EN: when defined, a tie goes to the port that
// did not win last (last = previous winner); otherwise load/store always
// beats fetch and no last-owner input exists.
//   req_if, req_ls : pending requests
//   last           : previous winner (round-robin build only)
//   any            : at least one request pending
//   win            : winning owner (OWN_IF / OWN_LS), valid when any=1
module arb_pick
  import arb_pkg::*;
(
  input  logic req_if,
  input  logic req_ls,
  output logic any,
  output logic win
`ifdef ARB_ROUND_ROBIN_EN
  ,
  input  logic last
`endif
);

  assign any = req_if | req_ls;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    win = OWN_IF;
    if (req_if && req_ls) begin
      win = ~last;
    end else if (req_ls) begin
      win = OWN_LS;
    end
  end
`else
  always_comb begin
    win = OWN_IF;
    if (req_ls) begin
      win = OWN_LS;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core's single memory port between
// instruction fetch (read-only) and load/store (read/write). One transaction
// is outstanding at a time; the winner's fields are latched at grant and
// held on the memory port until the memory accepts, then the response is
// routed back to the owning port.
// Build option ARB_ROUND_ROBIN_EN: round-robin tie-break (fetch wins the
// first tie after reset); undefined gives fixed load/store priority.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (fetch, load/store, memory, sel)
//
// state    | meaning
// ---------+------------------------------------------------------------
// ARB_IDLE | no transaction; grant and latch a winner if any request
// ARB_REQ  | mem_req asserted with latched fields, waiting for mem_gnt
// ARB_RESP | accepted by memory, waiting for mem_rvalid
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
) (
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave bus
);

  arb_state_e state, state_nxt;

  logic            owner_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wstrb_q;

  logic pick_any;
  logic pick_win;
  logic latch_en;

  logic if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  arb_pick u_pick (
    .req_if (bus.if_req),
    .req_ls (bus.ls_req),
    .any    (pick_any),
    .win    (pick_win),
    .last   (last_q)
  );

  // Reset to OWN_LS so fetch takes the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= OWN_LS;
    end else if (latch_en) begin
      last_q <= pick_win;
    end
  end
`else
  arb_pick u_pick (
    .req_if (bus.if_req),
    .req_ls (bus.ls_req),
    .any    (pick_any),
    .win    (pick_win)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    mem_req   = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          latch_en  = 1'b1;
          if_gnt    = (pick_win == OWN_IF);
          ls_gnt    = (pick_win == OWN_LS);
          state_nxt = ARB_REQ;
        end
      end
      ARB_REQ: begin
        mem_req = 1'b1;
        if (bus.mem_gnt) begin
          state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (bus.mem_rvalid) begin
          if_rvalid = (owner_q == OWN_IF);
          ls_rvalid = (owner_q == OWN_LS);
          state_nxt = ARB_IDLE;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Fetch is read-only, so its we/wstrb/wdata are forced to zero when latched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (latch_en) begin
      owner_q <= pick_win;
      if (pick_win == OWN_LS) begin
        we_q    <= bus.ls_we;
        addr_q  <= bus.ls_addr;
        wdata_q <= bus.ls_wdata;
        wstrb_q <= bus.ls_wstrb;
      end else begin
        we_q    <= 1'b0;
        addr_q  <= bus.if_addr;
        wdata_q <= '0;
        wstrb_q <= '0;
      end
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.if_rvalid = if_rvalid;
  assign bus.ls_rvalid = ls_rvalid;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

  // sel holds the last owner through IDLE so the shared mux does not toggle.
  assign bus.sel       = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change on the falling edge and
// outputs are checked 1 ns later, so combinational grants/responses are seen
// in the same cycle the arbiter registers them on the next rising edge.
module tb_mem_port_arbiter;
  import arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_if_rvalid"}, bus.if_rvalid, 1'b0);
    chk({tag, "_ls_rvalid"}, bus.ls_rvalid, 1'b0);
  endtask

  logic exp_win;

  initial begin
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.ls_req     = 1'b0;
    bus.ls_we      = 1'b0;
    bus.ls_addr    = '0;
    bus.ls_wdata   = '0;
    bus.ls_wstrb   = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    // reset values
    step(); step();
    settle();
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_sel", bus.sel, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 4'h0);
    chk("rst_if_gnt", bus.if_gnt, 1'b0);
    chk("rst_ls_gnt", bus.ls_gnt, 1'b0);
    check_quiet("rst");
    rst_n = 1'b1;

    // fetch only
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0100;
    settle();
    chk("f_if_gnt", bus.if_gnt, 1'b1);
    chk("f_ls_gnt", bus.ls_gnt, 1'b0);
    chk("f_mem_req_n", bus.mem_req, 1'b0);
    step();
    bus.if_req  = 1'b0;
    bus.mem_gnt = 1'b1;
    settle();
    chk("f_mem_req", bus.mem_req, 1'b1);
    chk("f_mem_addr", bus.mem_addr, 32'h100);
    chk("f_mem_we", bus.mem_we, 1'b0);
    chk("f_sel", bus.sel, OWN_IF);
    chk("f_if_gnt_once", bus.if_gnt, 1'b0);
    step();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    settle();
    chk("f_if_rvalid", bus.if_rvalid, 1'b1);
    chk("f_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    chk("f_ls_rvalid", bus.ls_rvalid, 1'b0);
    chk("f_mem_req_resp", bus.mem_req, 1'b0);
    step();
    bus.mem_rvalid = 1'b0;
    settle();
    check_quiet("f_idle");
    chk("f_idle_mem_req", bus.mem_req, 1'b0);

    // store with mem_gnt stalled 3 cycles
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 32'h2000_0004;
    bus.ls_wdata = 32'h1234_5678;
    bus.ls_wstrb = 4'b0011;
    settle();
    chk("s_ls_gnt", bus.ls_gnt, 1'b1);
    chk("s_if_gnt", bus.if_gnt, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      bus.ls_req   = 1'b0;
      bus.ls_we    = 1'b0;
      bus.ls_addr  = 32'hFFFF_FFFF;
      bus.ls_wdata = 32'h0;
      bus.ls_wstrb = 4'h0;
      bus.mem_gnt  = (i == 3);
      settle();
      chk("s_mem_req", bus.mem_req, 1'b1);
      chk("s_mem_we", bus.mem_we, 1'b1);
      chk("s_mem_addr", bus.mem_addr, 32'h2000_0004);
      chk("s_mem_wdata", bus.mem_wdata, 32'h1234_5678);
      chk("s_mem_wstrb", bus.mem_wstrb, 4'b0011);
      chk("s_sel", bus.sel, OWN_LS);
      check_quiet("s_stall");
    end
    step();
    bus.mem_gnt = 1'b0;
    settle();
    chk("s_resp_wait_req", bus.mem_req, 1'b0);
    check_quiet("s_resp_wait");
    step();
    bus.mem_rvalid = 1'b1;
    settle();
    chk("s_ls_rvalid", bus.ls_rvalid, 1'b1);
    chk("s_if_rvalid", bus.if_rvalid, 1'b0);
    step();
    bus.mem_rvalid = 1'b0;
    settle();
    check_quiet("s_after");
    chk("s_after_sel_hold", bus.sel, OWN_LS);

    // simultaneous requests, 4 back-to-back transactions
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_1000;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_win = (k % 2 == 0) ? OWN_IF : OWN_LS;
`else
      exp_win = OWN_LS;
`endif
      settle();
      chk("t_if_gnt", bus.if_gnt, (exp_win == OWN_IF));
      chk("t_ls_gnt", bus.ls_gnt, (exp_win == OWN_LS));
      step();
      bus.mem_gnt = 1'b1;
      settle();
      chk("t_sel", bus.sel, exp_win);
      chk("t_mem_addr", bus.mem_addr, (exp_win == OWN_LS) ? 32'h2000 : 32'h1000);
      chk("t_gnt_clear", bus.if_gnt | bus.ls_gnt, 1'b0);
      step();
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hA000_0000 + k;
      settle();
      chk("t_if_rvalid", bus.if_rvalid, (exp_win == OWN_IF));
      chk("t_ls_rvalid", bus.ls_rvalid, (exp_win == OWN_LS));
      step();
      bus.mem_rvalid = 1'b0;
    end
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;

    // stray responses: mem_rvalid in IDLE, mem_gnt in RESP
    step();
    bus.mem_rvalid = 1'b1;
    settle();
    check_quiet("x_idle_rvalid");
    chk("x_idle_req", bus.mem_req, 1'b0);
    step();
    bus.mem_rvalid = 1'b0;
    settle();
    chk("x_idle_stay", bus.mem_req, 1'b0);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0300;
    settle();
    chk("x_if_gnt", bus.if_gnt, 1'b1);
    step();
    bus.if_req  = 1'b0;
    bus.mem_gnt = 1'b1;
    settle();
    chk("x_mem_req", bus.mem_req, 1'b1);
    step();
    settle();
    chk("x_resp_gnt_req", bus.mem_req, 1'b0);
    check_quiet("x_resp_gnt");
    step();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0BAD_CAFE;
    settle();
    chk("x_if_rvalid", bus.if_rvalid, 1'b1);
    chk("x_if_rdata", bus.if_rdata, 32'h0BAD_CAFE);
    step();
    bus.mem_rvalid = 1'b0;

    // reset while in RESP, late mem_rvalid ignored
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 32'h3000_0000;
    bus.ls_wdata = 32'h5555_AAAA;
    bus.ls_wstrb = 4'hF;
    settle();
    chk("r_ls_gnt", bus.ls_gnt, 1'b1);
    step();
    bus.ls_req  = 1'b0;
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    rst_n       = 1'b0;
    settle();
    check_quiet("r_resp");
    step();
    rst_n          = 1'b1;
    bus.mem_rvalid = 1'b1;
    settle();
    check_quiet("r_late");
    chk("r_mem_req", bus.mem_req, 1'b0);
    chk("r_mem_we", bus.mem_we, 1'b0);
    chk("r_sel", bus.sel, 1'b0);
    chk("r_mem_addr", bus.mem_addr, 32'h0);
    chk("r_mem_wdata", bus.mem_wdata, 32'h0);
    chk("r_mem_wstrb", bus.mem_wstrb, 4'h0);
    step();
    bus.mem_rvalid = 1'b0;
    settle();
    chk("r_idle_req", bus.mem_req, 1'b0);
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 32'h0000_4444;
    settle();
    chk("r2_ls_gnt", bus.ls_gnt, 1'b1);
    step();
    bus.ls_req  = 1'b0;
    bus.mem_gnt = 1'b1;
    settle();
    chk("r2_mem_addr", bus.mem_addr, 32'h4444);
    chk("r2_mem_we", bus.mem_we, 1'b0);
    chk("r2_sel", bus.sel, OWN_LS);
    step();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h7777_8888;
    settle();
    chk("r2_ls_rvalid", bus.ls_rvalid, 1'b1);
    chk("r2_ls_rdata", bus.ls_rdata, 32'h7777_8888);
    chk("r2_if_rvalid", bus.if_rvalid, 1'b0);
    step();
    bus.mem_rvalid = 1'b0;
    settle();
    check_quiet("r2_done");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
